// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
//  Module      : alu_control
//  Description : Sequencing stage in front of the 8-bit ALU. It holds the A/B
//                operand registers and decodes a 3-bit command into ALU control
//                lines. It strobes the ALU output transceiver, then captures the
//                result, the N/Z flags and an internally computed carry. Commands
//                arrive through a valid/ready handshake, one every 4 cycles.
//  Optional    : ALU_CTRL_WRITEBACK_EN - accumulator mode. A <= ALU result at
//                capture for every op except CMP and the reserved op.
//  Ports       :
//    i_clk, i_nrst                  clock, asynchronous active-low reset
//    i_bus, i_loadA, i_loadB        operand loads (honoured in IDLE only)
//    i_valid, o_ready, i_op         command handshake and opcode
//    o_a, o_b                       operand registers to the ALU
//    o_aluOp, o_sub, o_shiftLeft    ALU control lines
//    o_aluCe                        ALU output transceiver enable
//    i_y, i_negative, i_zero        ALU result and flags
//    o_result, o_resultValid        captured result, one-cycle valid pulse
//    o_flagN, o_flagZ, o_flagC      flag register
//    o_err                          one-cycle pulse for the reserved opcode
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_control (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic [7:0] i_bus,
    input  logic       i_loadA,
    input  logic       i_loadB,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [2:0] i_op,
    output logic [7:0] o_a,
    output logic [7:0] o_b,
    output logic [1:0] o_aluOp,
    output logic       o_sub,
    output logic       o_shiftLeft,
    output logic       o_aluCe,
    input  logic [7:0] i_y,
    input  logic       i_negative,
    input  logic       i_zero,
    output logic [7:0] o_result,
    output logic       o_resultValid,
    output logic       o_flagN,
    output logic       o_flagZ,
    output logic       o_flagC,
    output logic       o_err
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_CMP  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_AND   = 2'b01;
    localparam logic [1:0] ALU_XOR   = 2'b10;
    localparam logic [1:0] ALU_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t     state_q;
    logic [2:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] result_q;
    logic [1:0] alu_op_q;
    logic       sub_q;
    logic       shl_q;
    logic       alu_ce_q;
    logic       res_valid_q;
    logic       err_q;
    logic       n_q;
    logic       z_q;
    logic       c_q;

    // Decode of the incoming opcode; only consumed at the accept edge.
    logic [1:0] w_dec_op;
    logic       w_dec_sub;
    logic       w_dec_shl;

    always_comb begin
        w_dec_op  = ALU_ADD;
        w_dec_sub = 1'b0;
        w_dec_shl = 1'b0;
        case (i_op)
            OP_ADD: w_dec_op = ALU_ADD;
            OP_SUB,
            OP_CMP: begin
                w_dec_op  = ALU_ADD;
                w_dec_sub = 1'b1;
            end
            OP_AND: w_dec_op = ALU_AND;
            OP_XOR: w_dec_op = ALU_XOR;
            OP_SHL: begin
                w_dec_op  = ALU_SHIFT;
                w_dec_shl = 1'b1;
            end
            OP_SHR: w_dec_op = ALU_SHIFT;
            default: w_dec_op = ALU_ADD;
        endcase
    end

    // Carry is not provided by the ALU, so it is rebuilt here from the held
    // operands: A + (B or ~B) + sub. For SUB/CMP bit 8 is the no-borrow flag.
    logic [8:0] w_sum;
    logic       w_arith;
    logic       w_carry;

    assign w_sum   = {1'b0, a_q} + {1'b0, (sub_q ? ~b_q : b_q)} + {8'd0, sub_q};
    assign w_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_CMP);
    assign w_carry = w_arith & w_sum[8];

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            result_q    <= 8'h00;
            alu_op_q    <= ALU_ADD;
            sub_q       <= 1'b0;
            shl_q       <= 1'b0;
            alu_ce_q    <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Loads land on the accept edge too, so a command issued
                    // together with a load operates on the new operands.
                    if (i_loadA) a_q <= i_bus;
                    if (i_loadB) b_q <= i_bus;
                    if (i_valid) begin
                        op_q <= i_op;
                        if (i_op == OP_RSVD) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            alu_op_q <= w_dec_op;
                            sub_q    <= w_dec_sub;
                            shl_q    <= w_dec_shl;
                            state_q  <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    alu_ce_q <= 1'b1;
                    state_q  <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    alu_ce_q <= 1'b0;
                    alu_op_q <= ALU_ADD;
                    sub_q    <= 1'b0;
                    shl_q    <= 1'b0;
                    n_q      <= i_negative;
                    z_q      <= i_zero;
                    c_q      <= w_carry;
                    if (op_q != OP_CMP) begin
                        result_q    <= i_y;
                        res_valid_q <= 1'b1;
`ifdef ALU_CTRL_WRITEBACK_EN
                        a_q         <= i_y;
`endif
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    res_valid_q <= 1'b0;
                    err_q       <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready       = (state_q == S_IDLE);
    assign o_a           = a_q;
    assign o_b           = b_q;
    assign o_aluOp       = alu_op_q;
    assign o_sub         = sub_q;
    assign o_shiftLeft   = shl_q;
    assign o_aluCe       = alu_ce_q;
    assign o_result      = result_q;
    assign o_resultValid = res_valid_q;
    assign o_flagN       = n_q;
    assign o_flagZ       = z_q;
    assign o_flagC       = c_q;
    assign o_err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_control
//  Description : Self-checking bench for alu_control. The bench plays the ALU
//                (combinational result driven only while the transceiver is
//                enabled) and compares every cycle against a cycle-count
//                reference model, followed by directed and random commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control;

    logic       i_clk = 1'b0;
    logic       i_nrst;
    logic [7:0] i_bus;
    logic       i_loadA, i_loadB, i_valid;
    logic [2:0] i_op;
    logic       o_ready;
    logic [7:0] o_a, o_b;
    logic [1:0] o_aluOp;
    logic       o_sub, o_shiftLeft, o_aluCe;
    logic [7:0] i_y;
    logic       i_negative, i_zero;
    logic [7:0] o_result;
    logic       o_resultValid, o_flagN, o_flagZ, o_flagC, o_err;

    always #5 i_clk = ~i_clk;

    alu_control dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_bus(i_bus),
        .i_loadA(i_loadA), .i_loadB(i_loadB),
        .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
        .o_a(o_a), .o_b(o_b), .o_aluOp(o_aluOp), .o_sub(o_sub),
        .o_shiftLeft(o_shiftLeft), .o_aluCe(o_aluCe),
        .i_y(i_y), .i_negative(i_negative), .i_zero(i_zero),
        .o_result(o_result), .o_resultValid(o_resultValid),
        .o_flagN(o_flagN), .o_flagZ(o_flagZ), .o_flagC(o_flagC), .o_err(o_err)
    );

    // Behavioural ALU; drives junk whenever the transceiver is disabled.
    logic [7:0] alu_y;
    always_comb begin
        alu_y = 8'h00;
        case (o_aluOp)
            2'b00: alu_y = o_sub ? (o_a - o_b) : (o_a + o_b);
            2'b01: alu_y = o_a & o_b;
            2'b10: alu_y = o_a ^ o_b;
            default: alu_y = o_shiftLeft ? (o_a << o_b[2:0]) : (o_a >> o_b[2:0]);
        endcase
        i_y        = o_aluCe ? alu_y : (~alu_y ^ 8'h5A);
        i_negative = i_y[7];
        i_zero     = (i_y == 8'h00);
    end

    int total = 0;
    int bad   = 0;

    // Reference model: architectural registers plus cycles elapsed since accept.
    bit       m_busy;
    int       m_el;
    bit [2:0] m_op;
    bit [7:0] m_a, m_b, m_res;
    bit       m_n, m_z, m_c;

    function automatic bit [3:0] exp_ctrl(input bit [2:0] op);
        case (op)
            3'd0:    return 4'b00_0_0;
            3'd1:    return 4'b00_1_0;
            3'd2:    return 4'b01_0_0;
            3'd3:    return 4'b10_0_0;
            3'd4:    return 4'b11_0_1;
            3'd5:    return 4'b11_0_0;
            3'd6:    return 4'b00_1_0;
            default: return 4'b00_0_0;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_el = 0; m_op = 0;
        m_a = 0; m_b = 0; m_res = 0; m_n = 0; m_z = 0; m_c = 0;
    endtask

    task automatic model_commit();
        bit [8:0] s;
        bit [7:0] y;
        bit       c;
        c = 0;
        case (m_op)
            3'd0: begin s = 9'(m_a) + 9'(m_b); y = s[7:0]; c = s[8]; end
            3'd1, 3'd6: begin y = m_a - m_b; c = (m_a >= m_b); end
            3'd2: y = m_a & m_b;
            3'd3: y = m_a ^ m_b;
            3'd4: y = m_a << m_b[2:0];
            default: y = m_a >> m_b[2:0];
        endcase
        m_n = y[7];
        m_z = (y == 8'h00);
        m_c = c;
        if (m_op != 3'd6) begin
            m_res = y;
`ifdef ALU_CTRL_WRITEBACK_EN
            m_a = y;
`endif
        end
    endtask

    task automatic model_edge(input bit v, input bit [2:0] op, input bit la,
                              input bit lb, input bit [7:0] bus);
        if (m_busy) begin
            m_el++;
            if (m_op == 3'd7) begin
                if (m_el == 1) m_busy = 0;
            end else begin
                if (m_el == 2) model_commit();
                if (m_el == 3) m_busy = 0;
            end
        end else begin
            if (la) m_a = bus;
            if (lb) m_b = bus;
            if (v) begin
                m_busy = 1; m_el = 0; m_op = op;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        bit normal;
        normal = m_busy && (m_op != 3'd7);
        chk("ready", 32'(o_ready), 32'(!m_busy));
        chk("ctrl", 32'({o_aluOp, o_sub, o_shiftLeft}),
            32'((normal && m_el <= 1) ? exp_ctrl(m_op) : 4'b0));
        chk("aluce", 32'(o_aluCe), 32'(normal && m_el == 1));
        chk("rvalid", 32'(o_resultValid), 32'(normal && m_op != 3'd6 && m_el == 2));
        chk("err", 32'(o_err), 32'(m_busy && m_op == 3'd7 && m_el == 0));
        chk("result", 32'(o_result), 32'(m_res));
        chk("flags", 32'({o_flagN, o_flagZ, o_flagC}), 32'({m_n, m_z, m_c}));
        chk("opa", 32'(o_a), 32'(m_a));
        chk("opb", 32'(o_b), 32'(m_b));
    endtask

    task automatic tick(input bit v, input bit [2:0] op, input bit la,
                        input bit lb, input bit [7:0] bus);
        i_valid = v; i_op = op; i_loadA = la; i_loadB = lb; i_bus = bus;
        @(posedge i_clk);
        model_edge(v, op, la, lb, bus);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 3'd0, 0, 0, 8'h00);
    endtask

    // Asserts reset between edges, checks the reset values, then releases.
    task automatic async_reset();
        #1 i_nrst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_rvalid", 32'(o_resultValid), 32'd0);
        #1 i_nrst = 1'b1;
    endtask

    task automatic load_ab(input bit [7:0] a, input bit [7:0] b);
        tick(0, 3'd0, 1, 0, a);
        tick(0, 3'd0, 0, 1, b);
    endtask

    task automatic run_op(input bit [2:0] op);
        tick(1, op, 0, 0, 8'h00);
        idle(op == 3'd7 ? 1 : 3);
    endtask

    initial begin
        int acc;
        int rv_at;
        i_nrst = 1'b0; i_valid = 0; i_op = 0; i_loadA = 0; i_loadB = 0; i_bus = 0;
        model_reset();
        #12;
        check_all();
        i_nrst = 1'b1;
        idle(2);

        // ADD with carry out, plus result-valid latency
        load_ab(8'hF0, 8'h20);
        tick(1, 3'd0, 0, 0, 8'h00);
        rv_at = 0;
        for (int i = 1; i <= 3; i++) begin
            tick(0, 3'd0, 0, 0, 8'h00);
            if (o_resultValid && rv_at == 0) rv_at = i + 1;
        end
        chk("add_latency", 32'(rv_at), 32'd3);
        chk("add_res", 32'(o_result), 32'h10);
        chk("add_flags", 32'({o_flagN, o_flagZ, o_flagC}), 32'b001);

        // SUB equal operands, then CMP A<B
        load_ab(8'h05, 8'h05);
        run_op(3'd1);
        chk("sub_res", 32'(o_result), 32'h00);
        chk("sub_flags", 32'({o_flagN, o_flagZ, o_flagC}), 32'b011);
        load_ab(8'h03, 8'h05);
        run_op(3'd6);
        chk("cmp_res", 32'(o_result), 32'h00);
        chk("cmp_flags", 32'({o_flagN, o_flagZ, o_flagC}), 32'b100);

        // Shifts with upper B bits set
        load_ab(8'h81, 8'hF9);
        run_op(3'd4);
        chk("shl_res", 32'(o_result), 32'h02);
        chk("shl_c", 32'(o_flagC), 32'd0);
        load_ab(8'h81, 8'hF9);
        run_op(3'd5);
        chk("shr_res", 32'(o_result), 32'h40);

        // Operand load during SETUP/CAPTURE is ignored
        load_ab(8'h09, 8'h05);
        tick(1, 3'd3, 0, 0, 8'h00);
        tick(0, 3'd0, 0, 1, 8'h33);
        tick(0, 3'd0, 0, 1, 8'h33);
        idle(1);
        chk("b_hold", 32'(o_b), 32'h05);
        chk("xor_res", 32'(o_result), 32'h0C);

        // Valid held high: one accept per 4 cycles
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_ready) acc++;
            tick(1, 3'd2, 0, 0, 8'h00);
        end
        chk("held_accepts", 32'(acc), 32'd3);

        // Reserved op: error pulse, flags untouched
        tick(1, 3'd7, 0, 0, 8'h00);
        chk("rsvd_err", 32'(o_err), 32'd1);
        idle(1);

        // Reset in SETUP aborts the command; next command is normal
        load_ab(8'h10, 8'h01);
        tick(1, 3'd0, 0, 0, 8'h00);
        async_reset();
        idle(3);
        load_ab(8'h22, 8'h11);
        run_op(3'd0);
        chk("post_rst_res", 32'(o_result), 32'h33);

        // Two ADDs of 1+1: writeback turns A into an accumulator
        load_ab(8'h01, 8'h01);
        run_op(3'd0);
        run_op(3'd0);
`ifdef ALU_CTRL_WRITEBACK_EN
        chk("wb_a", 32'(o_a), 32'h03);
`else
        chk("wb_a", 32'(o_a), 32'h01);
        chk("wb_res", 32'(o_result), 32'h02);
`endif

        // Random traffic, including load+accept on the same edge and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            tick($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
